// File: rtl/key_led_ctrl.sv
// Key-driven LED mode controller: synchronizes and debounces an active-low
// push-button, classifies short/long presses, and drives an active-low LED
// as OFF / ON / SLOW blink / FAST blink.
// Ports:
//   sys_clk, sys_rst_n : clock (rising edge), async active-low reset
//   key_1              : raw active-low button, asynchronous and bouncy
//   led_1              : registered active-low LED drive
//   mode               : current mode 0 OFF, 1 ON, 2 SLOW, 3 FAST
//   press_pulse        : one-cycle strobe per accepted short press
//   long_pulse         : one-cycle strobe when a press reaches the long threshold
module key_led_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
  parameter int unsigned LONG_PRESS_CYCLES = 100000000,
  parameter int unsigned SLOW_HALF_CYCLES  = 25000000,
  parameter int unsigned FAST_HALF_CYCLES  = 6250000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key_1,
  output logic       led_1,
  output logic [1:0] mode,
  output logic       press_pulse,
  output logic       long_pulse
);

  localparam int unsigned BLINK_MAX = (SLOW_HALF_CYCLES > FAST_HALF_CYCLES) ?
                                      SLOW_HALF_CYCLES : FAST_HALF_CYCLES;
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam int BL_W   = $clog2(BLINK_MAX + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [BL_W-1:0]   SLOW_LAST = BL_W'(SLOW_HALF_CYCLES - 1);
  localparam logic [BL_W-1:0]   FAST_LAST = BL_W'(FAST_HALF_CYCLES - 1);

  localparam logic [1:0] MODE_OFF  = 2'd0;
  localparam logic [1:0] MODE_ON   = 2'd1;
  localparam logic [1:0] MODE_FAST = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESSED   = 2'd1,
    ST_LONG_HELD = 2'd2
  } state_t;

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              settle1_q, settle1_d;
  logic              settle2_q, settle2_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic              key_db_q, key_db_d;
  logic              key_db_prev_q, key_db_prev_d;
  logic              armed_q, armed_d;
  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [1:0]        mode_q, mode_d;
  logic              press_q, press_d;
  logic              long_q, long_d;
  logic [BL_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic              phase_lit_q, phase_lit_d;
  logic              led_q, led_d;
  logic [BL_W-1:0]   half_last;

  logic key_fall;
  logic key_rise;

  assign key_fall = key_db_prev_q & ~key_db_q;
  assign key_rise = ~key_db_prev_q & key_db_q;

  always_comb begin
    sync1_d       = key_1;
    sync2_d       = sync1_q;
    // settle2_q goes high once sync2_q holds a real key sample instead of
    // its reset value.
    settle1_d     = 1'b1;
    settle2_d     = settle1_q;
    db_cnt_d      = '0;
    key_db_d      = key_db_q;
    key_db_prev_d = key_db_q;
    state_d       = state_q;
    hold_d        = hold_q;
    mode_d        = mode_q;
    press_d       = 1'b0;
    long_d        = 1'b0;
    blink_cnt_d   = blink_cnt_q;
    phase_lit_d   = phase_lit_q;
    led_d         = led_q;
    half_last     = (mode_q == MODE_FAST) ? FAST_LAST : SLOW_LAST;

    // Debounce: accept the new level only after DEBOUNCE_CYCLES consecutive
    // disagreeing samples; one agreeing sample restarts the count.
    if (sync2_q != key_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        key_db_d = sync2_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end

    // A key still held through reset must be seen released before a press
    // counts, so the first debounced fall after reset is ignored until the
    // synchronized key has been observed high.
    armed_d = armed_q | (settle2_q & sync2_q & key_db_q);

    case (state_q)
      ST_IDLE: begin
        if (key_fall && armed_q) begin
          state_d = ST_PRESSED;
          hold_d  = '0;
        end
      end
      ST_PRESSED: begin
        // Release wins over the long threshold if both land in one cycle.
        if (key_rise) begin
          state_d = ST_IDLE;
          press_d = 1'b1;
          mode_d  = mode_q + 2'd1;
        end else if (hold_q == HOLD_LAST) begin
          state_d = ST_LONG_HELD;
          long_d  = 1'b1;
          mode_d  = MODE_OFF;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_LONG_HELD: begin
        if (key_rise) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Blink timer restarts lit on every mode change, runs only in blink modes.
    if (mode_d != mode_q) begin
      blink_cnt_d = '0;
      phase_lit_d = 1'b1;
    end else if (mode_q[1]) begin
      if (blink_cnt_q == half_last) begin
        blink_cnt_d = '0;
        phase_lit_d = ~phase_lit_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end else begin
      blink_cnt_d = '0;
      phase_lit_d = 1'b1;
    end

    case (mode_q)
      MODE_OFF: led_d = 1'b1;
      MODE_ON:  led_d = 1'b0;
      default:  led_d = ~phase_lit_q;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      settle1_q     <= 1'b0;
      settle2_q     <= 1'b0;
      db_cnt_q      <= '0;
      key_db_q      <= 1'b1;
      key_db_prev_q <= 1'b1;
      armed_q       <= 1'b0;
      state_q       <= ST_IDLE;
      hold_q        <= '0;
      mode_q        <= MODE_OFF;
      press_q       <= 1'b0;
      long_q        <= 1'b0;
      blink_cnt_q   <= '0;
      phase_lit_q   <= 1'b1;
      led_q         <= 1'b1;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      settle1_q     <= settle1_d;
      settle2_q     <= settle2_d;
      db_cnt_q      <= db_cnt_d;
      key_db_q      <= key_db_d;
      key_db_prev_q <= key_db_prev_d;
      armed_q       <= armed_d;
      state_q       <= state_d;
      hold_q        <= hold_d;
      mode_q        <= mode_d;
      press_q       <= press_d;
      long_q        <= long_d;
      blink_cnt_q   <= blink_cnt_d;
      phase_lit_q   <= phase_lit_d;
      led_q         <= led_d;
    end
  end

  assign led_1       = led_q;
  assign mode        = mode_q;
  assign press_pulse = press_q;
  assign long_pulse  = long_q;

endmodule

// File: tb/tb_key_led_ctrl.sv
`timescale 1ns/1ps
module tb_key_led_ctrl;

  localparam int DB = 4;
  localparam int LP = 20;
  localparam int SH = 8;
  localparam int FH = 2;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       key_1;
  logic       led_1;
  logic [1:0] mode;
  logic       press_pulse;
  logic       long_pulse;

  key_led_ctrl #(
    .DEBOUNCE_CYCLES  (DB),
    .LONG_PRESS_CYCLES(LP),
    .SLOW_HALF_CYCLES (SH),
    .FAST_HALF_CYCLES (FH)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .key_1      (key_1),
    .led_1      (led_1),
    .mode       (mode),
    .press_pulse(press_pulse),
    .long_pulse (long_pulse)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_long;
    logic [1:0] mode;
    int         cyc;
  } ev_t;

  ev_t        sb[$];
  ev_t        got_ev;
  int         n_total = 0;
  int         n_bad   = 0;
  logic [1:0] exp_mode = 2'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Pulse monitor: every strobe must match the oldest expected event.
  always @(negedge sys_clk) begin
    if (press_pulse || long_pulse) begin
      chk("pulse_excl", 32'(press_pulse & long_pulse), 32'd0);
      if (sb.size() == 0) begin
        chk("unexp_pulse", 32'({press_pulse, long_pulse}), 32'd0);
      end else begin
        got_ev = sb.pop_front();
        chk("ev_kind", 32'(long_pulse), 32'(got_ev.is_long));
        chk("ev_cyc", 32'(cyc), 32'(got_ev.cyc));
        chk("ev_mode", 32'(mode), 32'(got_ev.mode));
      end
    end
  end

  task automatic wait_until(input int target);
    int g;
    g = 0;
    @(negedge sys_clk);
    while (cyc < target && g < 2000) begin
      @(negedge sys_clk);
      g++;
    end
    chk("cyc_align", 32'(cyc), 32'(target));
  endtask

  // Press for n cycles; pushes the expected strobe before driving.
  task automatic press_key(input int n, output int ev_c, output int rel_c);
    int  c0;
    ev_t e;
    @(posedge sys_clk); #1;
    key_1 = 1'b0;
    c0 = cyc;
    if (n <= LP) begin
      exp_mode  = exp_mode + 2'd1;
      e.is_long = 1'b0;
      e.mode    = exp_mode;
      e.cyc     = c0 + n + DB + 3;
    end else begin
      exp_mode  = 2'd0;
      e.is_long = 1'b1;
      e.mode    = 2'd0;
      e.cyc     = c0 + LP + DB + 3;
    end
    sb.push_back(e);
    ev_c = e.cyc;
    repeat (n) @(posedge sys_clk);
    #1;
    key_1 = 1'b1;
    rel_c = cyc;
  endtask

  task automatic short_check();
    int ev;
    int rel;
    press_key(10, ev, rel);
    wait_until(ev + 1);
    chk("short_mode", 32'(mode), 32'(exp_mode));
    chk("short_led", 32'(led_1), (exp_mode == 2'd0) ? 32'd1 : 32'd0);
    repeat (3) @(posedge sys_clk);
    #1;
  endtask

  task automatic check_blink(input int c_m, input int half, input int n);
    wait_until(c_m + 1);
    for (int i = 0; i < n; i++) begin
      chk("blink_led", 32'(led_1), (((i / half) % 2) != 0) ? 32'd1 : 32'd0);
      @(negedge sys_clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int   ev;
    int   rel;
    int   c0;
    int   n;
    logic db_low;
    ev_t  e;

    sys_rst_n = 1'b1;
    key_1     = 1'b1;
    #1 sys_rst_n = 1'b0;
    #1;
    chk("rst_led", 32'(led_1), 32'd1);
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_press", 32'(press_pulse), 32'd0);
    chk("rst_long", 32'(long_pulse), 32'd0);
    repeat (3) @(posedge sys_clk);
    #3 sys_rst_n = 1'b1;
    repeat (5) @(posedge sys_clk);
    #1;

    // Glitches one cycle shorter than the debounce window.
    for (int r = 0; r < 10; r++) begin
      key_1 = 1'b0;
      repeat (3) @(posedge sys_clk);
      #1;
      key_1 = 1'b1;
      repeat (4) @(posedge sys_clk);
      #1;
    end
    repeat (8) @(posedge sys_clk);
    #1;
    chk("glitch_db", 32'(dut.key_db_q), 32'd1);
    chk("glitch_mode", 32'(mode), 32'd0);
    chk("glitch_led", 32'(led_1), 32'd1);

    // Short presses cycle OFF -> ON -> SLOW -> FAST -> OFF.
    repeat (4) short_check();

    // SLOW then FAST blinking.
    short_check();
    press_key(10, ev, rel);
    check_blink(ev, SH, 40);
    press_key(10, ev, rel);
    check_blink(ev, FH, 16);

    // Back to SLOW, then a long press forces OFF with no release strobe.
    repeat (3) short_check();
    press_key(30, ev, rel);
    wait_until(rel + 12);
    chk("long_mode", 32'(mode), 32'd0);
    chk("long_led", 32'(led_1), 32'd1);

    // Reach FAST, then reset while the key is held.
    repeat (3) short_check();
    @(posedge sys_clk); #1;
    key_1 = 1'b0;
    repeat (15) @(posedge sys_clk);
    #3 sys_rst_n = 1'b0;
    #1;
    chk("rst2_led", 32'(led_1), 32'd1);
    chk("rst2_mode", 32'(mode), 32'd0);
    chk("rst2_press", 32'(press_pulse), 32'd0);
    chk("rst2_long", 32'(long_pulse), 32'd0);
    chk("rst2_db", 32'(dut.key_db_q), 32'd1);
    exp_mode = 2'd0;
    repeat (3) @(posedge sys_clk);
    #3 sys_rst_n = 1'b1;
    repeat (40) @(posedge sys_clk);
    #1;
    chk("held_mode", 32'(mode), 32'd0);
    chk("held_led", 32'(led_1), 32'd1);
    key_1 = 1'b1;
    repeat (15) @(posedge sys_clk);
    #1;
    chk("rel_mode", 32'(mode), 32'd0);
    short_check();

    // Bounce then stable low: single debounced fall DB+2 cycles later.
    db_low = 1'b0;
    for (int i = 0; i < 12; i++) begin
      key_1 = ((i % 2) != 0) ? 1'b1 : 1'b0;
      @(posedge sys_clk); #1;
      if (dut.key_db_q == 1'b0) db_low = 1'b1;
    end
    key_1 = 1'b0;
    c0 = cyc;
    n = 0;
    while (n < 20) begin
      @(posedge sys_clk); #1;
      n++;
      if (dut.key_db_q == 1'b0) break;
    end
    chk("bounce_db", 32'(db_low), 32'd0);
    chk("db_fall_lat", 32'(n), 32'(DB + 2));
    chk("db_fall_cyc", 32'(cyc - c0), 32'(DB + 2));
    repeat (10 - n) @(posedge sys_clk);
    #1;
    exp_mode  = exp_mode + 2'd1;
    e.is_long = 1'b0;
    e.mode    = exp_mode;
    e.cyc     = cyc + DB + 3;
    sb.push_back(e);
    key_1 = 1'b1;
    wait_until(e.cyc + 1);
    chk("bounce_mode", 32'(mode), 32'(exp_mode));

    repeat (20) @(posedge sys_clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/key_led_ctrl.md
KEY_LED_CTRL -- requirements
Module: key_led_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, meaning consecutive stable cycles required to accept a key level change (20 ms at 50 MHz).
REQ-002 Parameter LONG_PRESS_CYCLES, default 100000000, meaning cycles the debounced key must stay pressed to count as a long press.
REQ-003 Parameter SLOW_HALF_CYCLES, default 25000000, meaning LED half-period in SLOW blink mode.
REQ-004 Parameter FAST_HALF_CYCLES, default 6250000, meaning LED half-period in FAST blink mode.
REQ-005 sys_clk  input  1  system clock; all logic on its rising edge.
REQ-006 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-007 key_1  input  1  raw push-button, active-low (0 = pressed), asynchronous to sys_clk, bouncy.
REQ-008 led_1  output  1  registered LED drive, active-low (0 = lit).
REQ-009 mode  output  2  current LED mode: 0 OFF, 1 ON, 2 SLOW, 3 FAST.
REQ-010 press_pulse  output  1  one-cycle strobe on each accepted short press.
REQ-011 long_pulse  output  1  one-cycle strobe when a press crosses LONG_PRESS_CYCLES.

Function
REQ-012 key_1 SHALL pass through a two-flop synchronizer; both flops reset to 1.
REQ-013 Debounced level key_db (reset 1) SHALL change only after the synchronized key has differed from key_db for DEBOUNCE_CYCLES consecutive cycles; any cycle of agreement SHALL clear the debounce counter to 0.
REQ-014 Debounce counter SHALL saturate/clear on acceptance, never wrap.
REQ-015 Press FSM SHALL have states IDLE, PRESSED, LONG_HELD; reset state IDLE.
REQ-016 IDLE -> PRESSED on key_db falling edge; hold counter cleared to 0.
REQ-017 In PRESSED the hold counter SHALL increment each cycle; on reaching LONG_PRESS_CYCLES-1 the FSM SHALL go to LONG_HELD, assert long_pulse for one cycle and force mode to OFF.
REQ-018 PRESSED -> IDLE on key_db rising edge (release before long threshold): assert press_pulse for one cycle and advance mode OFF->ON->SLOW->FAST->OFF (wrap 3->0).
REQ-019 LONG_HELD -> IDLE on key_db rising edge with no press_pulse and no mode change.
REQ-020 Hold counter SHALL stop (not wrap) in LONG_HELD.
REQ-021 Blink timer SHALL run only in SLOW/FAST; it counts 0..HALF-1 for the active mode, then toggles blink phase and restarts at 0.
REQ-022 Any mode change SHALL clear the blink timer and set blink phase to lit in the same cycle the new mode takes effect.
REQ-023 led_1 SHALL be registered, one cycle after mode/phase: OFF -> 1, ON -> 0, SLOW/FAST -> 0 when phase lit, 1 otherwise.
REQ-024 press_pulse and long_pulse SHALL never assert in the same cycle and never for more than one cycle per event.
REQ-025 Latency: raw key edge to key_db change = 2 sync cycles + DEBOUNCE_CYCLES (+1 register) cycles; press_pulse in the cycle after key_db rises.

Reset
REQ-026 On sys_rst_n low, immediately and regardless of clock: led_1=1, mode=0, press_pulse=0, long_pulse=0, key_db=1, synchronizer=1, FSM=IDLE, all counters=0, blink phase=lit.
REQ-027 Reset asserted mid-press or mid-blink SHALL abort the operation with no pulse emitted; after release the block SHALL require a fresh debounced falling edge before any press is recognized, even if key_1 is still held low.

Verification (DEBOUNCE=4, LONG=20, SLOW_HALF=8, FAST_HALF=2)
REQ-028 Hold key_1=0 for 3 cycles then 1, repeated 10 times -> key_db stays 1, no pulses, mode=0, led_1=1.
REQ-029 Press 10 cycles, release -> exactly one press_pulse, mode 0->1, led_1=0 next cycle; repeat 4 times -> mode 1,2,3,0 and led_1=1 at end.
REQ-030 mode=2 held 40 cycles -> led_1 toggles every 8 cycles starting lit; one press -> mode=3, timer restarts lit, toggles every 2 cycles.
REQ-031 From mode=2 press and hold 30 cycles -> long_pulse once at hold count 19, mode=0, led_1=1; release -> no press_pulse, mode stays 0.
REQ-032 Assert sys_rst_n=0 while key held and mode=3, release reset with key still 0 -> all outputs at reset values, no pulse until key released and pressed again.
REQ-033 Key bounce (0/1 alternating each cycle) for 12 cycles then stable 0 -> single key_db fall exactly DEBOUNCE_CYCLES after stabilization plus 2 sync cycles.
